store_capture: RTL and testbench

STORE_CAPTURE -- requirements
Module: store_capture

---
 rtl/store_capture.sv | 91 +++++++++
 tb/tb_store_capture.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/store_capture.sv
// Captures CPU store transactions into a small FIFO for a downstream consumer,
// and tracks sticky status (overflow, misaligned, end-of-test done/pass).
module store_capture #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] DONE_ADDR = 32'd100,
  parameter logic [31:0] DONE_DATA = 32'd25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [15:0] count,
  output logic        overflow,
  output logic        misaligned,
  output logic        done,
  output logic        done_pass
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     occ;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;

  // DEPTH is a power of two and occ never exceeds it, so the MSB alone marks full.
  assign full      = occ[AW];
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts.
  assign push      = MemWrite && (!full || pop);
  assign drop      = MemWrite && full && !pop;

  assign out_addr  = out_valid ? mem[head].addr : '0;
  assign out_data  = out_valid ? mem[head].data : '0;

  // NOTE: the storage array has no reset; occupancy gates every read, so stale
  // contents are never observable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[tail] <= '{addr: DataAdr, data: WriteData};
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      misaligned <= 1'b0;
      done       <= 1'b0;
      done_pass  <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;

      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;

      if (push && count != 16'hFFFF) count <= count + 16'd1;
      if (drop)                      overflow <= 1'b1;

      if (MemWrite && DataAdr[1:0] != 2'b00) misaligned <= 1'b1;

      // Only the first store to the done address decides the verdict.
      if (MemWrite && DataAdr == DONE_ADDR && !done) begin
        done      <= 1'b1;
        done_pass <= (WriteData == DONE_DATA);
      end
    end
  end

endmodule

// File: tb/tb_store_capture.sv
// Randomized + directed bench for store_capture: a queue-based reference model
// feeds a scoreboard that a negedge monitor drains against the DUT outputs.
module tb_store_capture;

  localparam int          DEPTH     = 8;
  localparam logic [31:0] DONE_ADDR = 32'd100;
  localparam logic [31:0] DONE_DATA = 32'd25;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [15:0] count;
  logic        overflow;
  logic        misaligned;
  logic        done;
  logic        done_pass;

  store_capture #(
    .DEPTH(DEPTH), .DONE_ADDR(DONE_ADDR), .DONE_DATA(DONE_DATA)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .count(count),
    .overflow(overflow), .misaligned(misaligned), .done(done),
    .done_pass(done_pass)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: accepted stores are pushed onto the scoreboard queue,
  // occupancy and flags are tracked as plain integers/bits.
  logic [63:0] exp_q[$];
  int          m_occ  = 0;
  int          m_cnt  = 0;
  bit          m_ovf  = 0;
  bit          m_mis  = 0;
  bit          m_done = 0;
  bit          m_pass = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    bit do_pop;
    chk_en <= 1'b1;
    if (reset) begin
      exp_q.delete();
      m_occ = 0; m_cnt = 0; m_ovf = 0; m_mis = 0; m_done = 0; m_pass = 0;
    end else begin
      do_pop = (m_occ > 0) && out_ready;
      if (do_pop) m_occ--;
      if (MemWrite) begin
        if (DataAdr % 4 != 0) m_mis = 1;
        if (DataAdr == DONE_ADDR && !m_done) begin
          m_done = 1;
          m_pass = (WriteData == DONE_DATA);
        end
        if (m_occ < DEPTH) begin
          m_occ++;
          exp_q.push_back({DataAdr, WriteData});
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires the head on a handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_occ != 0});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_underrun", 32'd1, 32'd0);
        end else begin
          check("out_addr", out_addr, exp_q[0][63:32]);
          check("out_data", out_data, exp_q[0][31:0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_addr", out_addr, 32'd0);
        check("idle_data", out_data, 32'd0);
      end
      check("count",      {16'd0, count},      m_cnt);
      check("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
      check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
      check("done",       {31'd0, done},       {31'd0, m_done});
      check("done_pass",  {31'd0, done_pass},  {31'd0, m_pass});
    end
  end

  task automatic step(input logic rst, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    reset = rst; MemWrite = we; DataAdr = a; WriteData = d; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, i[0], 32'h40 + i, 32'hA5A5_0000 + i, i[1]);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    // Reset held 3 cycles with stores toggling, then one idle cycle.
    do_reset(3);
    step(1'b0, 1'b0, '0, '0, 1'b0);

    // Single store held while the consumer stalls.
    step(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
    drain(2);

    // Overfill: 10 stores into 8 entries, then drain in order.
    do_reset(1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h100 + 4 * i, 32'h1000 + i, 1'b0);
    drain(10);

    // Full FIFO with a concurrent push and pop.
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h200 + 4 * i, 32'h2000 + i, 1'b0);
    step(1'b0, 1'b1, 32'h300, 32'h3000, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    drain(10);

    // Empty FIFO: push and out_ready together only pushes.
    step(1'b0, 1'b1, 32'h44, 32'h4444, 1'b1);
    drain(2);

    // Done detection: pass case, later done-address store ignored.
    do_reset(1);
    step(1'b0, 1'b1, DONE_ADDR, 32'd25, 1'b1);
    step(1'b0, 1'b1, DONE_ADDR, 32'd7,  1'b1);
    drain(3);
    // Fail case.
    do_reset(1);
    step(1'b0, 1'b1, DONE_ADDR, 32'd24, 1'b0);
    step(1'b0, 1'b1, DONE_ADDR, 32'd25, 1'b0);
    drain(3);

    // Misaligned store, reset mid-drain, store on the first cycle after reset.
    do_reset(1);
    step(1'b0, 1'b1, 32'h66, 32'h6666, 1'b0);
    step(1'b0, 1'b1, 32'h68, 32'h6868, 1'b0);
    step(1'b0, 1'b1, 32'h6C, 32'h6C6C, 1'b1);
    do_reset(2);
    step(1'b0, 1'b1, 32'h70, 32'h7070, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    drain(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       a = DONE_ADDR;
        1:       a = 32'h66;
        2:       a = $urandom & 32'hFFFF_FFFC;
        default: a = $urandom;
      endcase
      d = ($urandom_range(0, 3) == 0) ? DONE_DATA : $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, a, d,
           $urandom_range(0, 9) < (i % 700 < 350 ? 3 : 7));
    end
    drain(DEPTH + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
